// File: rtl/exe_trap_unit_pkg.sv
// Shared definitions for the EXE-stage trap/redirect controller.
// Pure declarations: no logic, no latency.
// No flow control.
package exe_trap_unit_pkg;

  // Synchronous exception cause codes (mcause with interrupt bit clear)
  localparam int unsigned CAUSE_PC_MISAL  = 0;
  localparam int unsigned CAUSE_ILLEGAL   = 2;
  localparam int unsigned CAUSE_BREAK     = 3;
  localparam int unsigned CAUSE_LD_MISAL  = 4;
  localparam int unsigned CAUSE_LD_FAULT  = 5;
  localparam int unsigned CAUSE_ST_MISAL  = 6;
  localparam int unsigned CAUSE_ST_FAULT  = 7;
  localparam int unsigned CAUSE_ECALL_U   = 8;
  localparam int unsigned CAUSE_ECALL_S   = 9;
  localparam int unsigned CAUSE_ECALL_M   = 11;

  // Privilege levels
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  // mtvec MODE field encodings
  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  // Qualified synchronous fault/ecall flags of the EXE instruction
  typedef struct packed {
    logic pc_misal;
    logic illegal;
    logic brk;
    logic ld_misal;
    logic ld_fault;
    logic st_misal;
    logic st_fault;
    logic ecall;
  } fault_t;

  // Interrupt line index to cause code
  function automatic int unsigned irq_code(input int unsigned idx);
    return 4 * idx + 3;
  endfunction

endpackage

// File: rtl/exe_trap_unit_trap_prio_enc.sv
// Trap priority encoder: picks interrupt vs synchronous cause for the EXE instruction.
// Latency: purely combinational.
// No flow control; caller gates with ev (valid and not squashed).
module trap_prio_enc
  import exe_trap_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NB_IRQ = 3
) (
  input  logic              ev,
  input  logic              mie,
  input  fault_t            fault,
  input  logic [NB_IRQ-1:0] irq,
  input  logic [1:0]        mode,
  output logic              trap,
  output logic              is_irq,
  output logic [XLEN-1:0]   cause
);

  localparam int CW = XLEN - 1;

  logic [CW-1:0] irq_cd;
  logic [CW-1:0] sync_cd;
  logic          sync_any;

  // Highest pending interrupt index wins: later loop iterations override
  always_comb begin
    irq_cd = '0;
    for (int i = 0; i < NB_IRQ; i++) begin
      if (irq[i]) irq_cd = CW'(irq_code(i));
    end
  end

  // Fixed synchronous priority; ecall cause depends on current privilege
  always_comb begin
    sync_cd  = '0;
    sync_any = |fault;
    if (fault.pc_misal)      sync_cd = CW'(CAUSE_PC_MISAL);
    else if (fault.illegal)  sync_cd = CW'(CAUSE_ILLEGAL);
    else if (fault.brk)      sync_cd = CW'(CAUSE_BREAK);
    else if (fault.ld_misal) sync_cd = CW'(CAUSE_LD_MISAL);
    else if (fault.ld_fault) sync_cd = CW'(CAUSE_LD_FAULT);
    else if (fault.st_misal) sync_cd = CW'(CAUSE_ST_MISAL);
    else if (fault.st_fault) sync_cd = CW'(CAUSE_ST_FAULT);
    else if (fault.ecall) begin
      case (mode)
        PRIV_U:  sync_cd = CW'(CAUSE_ECALL_U);
        PRIV_S:  sync_cd = CW'(CAUSE_ECALL_S);
        default: sync_cd = CW'(CAUSE_ECALL_M);
      endcase
    end
  end

  // Interrupts pre-empt any synchronous fault on the same instruction
  always_comb begin
    is_irq = ev & mie & (|irq);
    trap   = is_irq | (ev & sync_any);
    cause  = is_irq ? {1'b1, irq_cd} : {1'b0, sync_cd};
  end

endmodule

// File: rtl/exe_trap_unit.sv
// EXE-stage trap/redirect controller: squash, trap CSR payload, fetch redirect, privilege tracking.
// Latency: squash_o combinational; all *_q_o outputs registered, 1 cycle after the EXE cycle.
// No backpressure; a flush shadow of FLUSH_DEPTH cycles kills EXE instructions after any redirect.
module exe_trap_unit
  import exe_trap_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int NB_IRQ      = 3,
  parameter bit VECTORED_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inst_v_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              pc_misaligned_i,
  input  logic              illegal_inst_i,
  input  logic              break_point_i,
  input  logic              ld_misaligned_i,
  input  logic              ld_fault_i,
  input  logic              st_misaligned_i,
  input  logic              st_fault_i,
  input  logic              ecall_i,
  input  logic              mret_i,
  input  logic              sret_i,
  input  logic              branch_v_i,
  input  logic [XLEN-1:0]   branch_pc_i,
  input  logic [XLEN-1:0]   mem_adr_i,
  input  logic [NB_IRQ-1:0] irq_pending_i,
  input  logic              mie_i,
  input  logic [XLEN-1:0]   mtvec_i,
  input  logic [XLEN-1:0]   mepc_i,
  input  logic [XLEN-1:0]   sepc_i,
  output logic              squash_o,
  output logic              flush_v_q_o,
  output logic [XLEN-1:0]   pc_data_q_o,
  output logic              exception_q_o,
  output logic [XLEN-1:0]   mcause_q_o,
  output logic [XLEN-1:0]   mtval_q_o,
  output logic [XLEN-1:0]   mepc_q_o,
  output logic [1:0]        core_mode_q_o,
  output logic [1:0]        mpp_q_o
);

  localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

  logic [CNT_W-1:0] shadow_cnt_q;
  logic             kill;
  logic             ev;
  fault_t           fault;
  logic             trap;
  logic             is_irq;
  logic [XLEN-1:0]  cause;
  logic             redirect;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  trap_base;
  logic [XLEN-1:0]  trap_val;

  // Qualify the instruction against the flush shadow and pack fault flags
  always_comb begin
    kill           = (shadow_cnt_q != '0);
    ev             = inst_v_i & ~kill;
    fault.pc_misal = pc_misaligned_i;
    fault.illegal  = illegal_inst_i;
    fault.brk      = break_point_i;
    fault.ld_misal = ld_misaligned_i;
    fault.ld_fault = ld_fault_i;
    fault.st_misal = st_misaligned_i;
    fault.st_fault = st_fault_i;
    fault.ecall    = ecall_i;
  end

  trap_prio_enc #(
    .XLEN   (XLEN),
    .NB_IRQ (NB_IRQ)
  ) u_prio (
    .ev     (ev),
    .mie    (mie_i),
    .fault  (fault),
    .irq    (irq_pending_i),
    .mode   (core_mode_q_o),
    .trap   (trap),
    .is_irq (is_irq),
    .cause  (cause)
  );

  // Redirect decision and target: trap > mret > sret > branch
  always_comb begin
    redirect  = trap | (ev & (mret_i | sret_i | branch_v_i));
    trap_base = {mtvec_i[XLEN-1:2], 2'b00};
    target    = branch_pc_i;
    if (trap) begin
      target = trap_base;
      if (VECTORED_EN && is_irq && (mtvec_i[1:0] == MTVEC_VECTORED)) begin
        // 4*code: the interrupt bit falls off the top of the shift
        target = trap_base + {cause[XLEN-3:0], 2'b00};
      end
    end else if (mret_i) begin
      target = mepc_i;
    end else if (sret_i) begin
      target = sepc_i;
    end
  end

  // Killed instructions, traps and xrets never write; a taken branch keeps its link write
  always_comb begin
    squash_o = kill | trap | (inst_v_i & redirect & ~branch_v_i);
  end

  // mtval follows whichever synchronous fault won the priority; interrupts report 0
  always_comb begin
    trap_val = '0;
    if (!is_irq) begin
      if (pc_misaligned_i) begin
        trap_val = branch_pc_i;
      end else if (illegal_inst_i || break_point_i) begin
        trap_val = '0;
      end else if (ld_misaligned_i || ld_fault_i || st_misaligned_i || st_fault_i) begin
        trap_val = mem_adr_i;
      end
    end
  end

  // Flush shadow: reload on every redirect, otherwise count down to idle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow_cnt_q <= '0;
    end else if (redirect) begin
      shadow_cnt_q <= CNT_W'(FLUSH_DEPTH);
    end else if (shadow_cnt_q != '0) begin
      shadow_cnt_q <= shadow_cnt_q - 1'b1;
    end
  end

  // Redirect and trap payload registers; pulses last exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_v_q_o   <= 1'b0;
      exception_q_o <= 1'b0;
      pc_data_q_o   <= '0;
      mcause_q_o    <= '0;
      mtval_q_o     <= '0;
      mepc_q_o      <= '0;
    end else begin
      flush_v_q_o   <= redirect;
      exception_q_o <= trap;
      if (redirect) pc_data_q_o <= target;
      if (trap) begin
        mcause_q_o <= cause;
        mtval_q_o  <= trap_val;
        mepc_q_o   <= pc_i;
      end
    end
  end

  // Privilege tracking; a trap overrides a simultaneous xret
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_mode_q_o <= PRIV_M;
      mpp_q_o       <= PRIV_U;
    end else if (trap) begin
      mpp_q_o       <= core_mode_q_o;
      core_mode_q_o <= PRIV_M;
    end else if (ev && mret_i) begin
      core_mode_q_o <= mpp_q_o;
      mpp_q_o       <= PRIV_U;
    end else if (ev && sret_i) begin
      core_mode_q_o <= PRIV_S;
    end
  end

endmodule

// File: tb/tb_exe_trap_unit.sv
// Self-checking bench for exe_trap_unit: reference model compared every cycle plus directed literals.
// Inputs change 1 time unit after posedge; outputs are compared on negedge.
// Bench runs a fixed, finite stimulus sequence.
module tb_exe_trap_unit;

  localparam int XLEN = 32;
  localparam int FD   = 2;
  localparam int NB   = 3;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            inst_v, pc_mis, ill, brk, ldm, ldf, stm, stf, ecall, mret, sret, br_v, mie;
  logic [XLEN-1:0] pc, br_pc, mem_adr, mtvec, mepc, sepc;
  logic [NB-1:0]   irq;
  logic            squash, flush_v, exc;
  logic [XLEN-1:0] pc_data, mcause, mtval, mepc_q;
  logic [1:0]      mode, mpp;

  always #5 clk = ~clk;

  exe_trap_unit #(.XLEN(XLEN), .FLUSH_DEPTH(FD), .NB_IRQ(NB), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .inst_v_i(inst_v), .pc_i(pc),
    .pc_misaligned_i(pc_mis), .illegal_inst_i(ill), .break_point_i(brk),
    .ld_misaligned_i(ldm), .ld_fault_i(ldf), .st_misaligned_i(stm), .st_fault_i(stf),
    .ecall_i(ecall), .mret_i(mret), .sret_i(sret), .branch_v_i(br_v), .branch_pc_i(br_pc),
    .mem_adr_i(mem_adr), .irq_pending_i(irq), .mie_i(mie), .mtvec_i(mtvec),
    .mepc_i(mepc), .sepc_i(sepc), .squash_o(squash), .flush_v_q_o(flush_v),
    .pc_data_q_o(pc_data), .exception_q_o(exc), .mcause_q_o(mcause), .mtval_q_o(mtval),
    .mepc_q_o(mepc_q), .core_mode_q_o(mode), .mpp_q_o(mpp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_ok = 1'b0;
  int          m_shadow;
  logic        m_flush, m_exc;
  logic [31:0] m_pc_data, m_mcause, m_mtval, m_mepc;
  logic [1:0]  m_mode, m_mpp;

  // What this cycle's EXE instruction must do, from the architectural rules
  function automatic void model_eval(output bit live, output bit trap, output bit is_irq,
                                     output logic [31:0] cause, output logic [31:0] tval,
                                     output logic [31:0] tgt, output bit redir, output bit sq);
    bit          flt[7];
    int          code[7];
    bit          found;
    logic [31:0] base;
    flt  = '{pc_mis, ill, brk, ldm, ldf, stm, stf};
    code = '{0, 2, 3, 4, 5, 6, 7};
    live = inst_v && (m_shadow == 0);
    trap = 0; is_irq = 0; cause = 0; tval = 0; found = 0;
    if (live && mie && irq != 0) begin
      for (int i = NB - 1; i >= 0; i--)
        if (irq[i] && !found) begin
          found = 1; cause = 32'h8000_0000 + 32'(4 * i + 3);
        end
      trap = 1; is_irq = 1;
    end else if (live) begin
      for (int k = 0; k < 7; k++)
        if (flt[k] && !trap) begin
          trap = 1; cause = 32'(code[k]);
          tval = (k == 0) ? br_pc : ((k >= 3) ? mem_adr : 32'h0);
        end
      if (!trap && ecall) begin
        trap  = 1;
        cause = (m_mode == 2'b00) ? 32'd8 : (m_mode == 2'b01) ? 32'd9 : 32'd11;
      end
    end
    redir = trap || (live && (mret || sret || br_v));
    base  = mtvec & ~32'h3;
    if (trap) tgt = (is_irq && mtvec[1:0] == 2'b01) ? base + 4 * (cause & 32'h7FFF_FFFF) : base;
    else if (mret) tgt = mepc;
    else if (sret) tgt = sepc;
    else tgt = br_pc;
    sq = (m_shadow != 0) || trap || (inst_v && redir && !br_v);
  endfunction

  always @(posedge clk) begin
    bit live, trap, is_irq, redir, sq;
    logic [31:0] cause, tval, tgt;
    if (!reset_n) begin
      m_shadow = 0; m_flush = 0; m_exc = 0; m_pc_data = 0; m_mcause = 0;
      m_mtval = 0; m_mepc = 0; m_mode = 2'b11; m_mpp = 2'b00; m_ok = 1'b1;
    end else if (m_ok) begin
      model_eval(live, trap, is_irq, cause, tval, tgt, redir, sq);
      m_flush = redir;
      m_exc   = trap;
      if (redir) m_pc_data = tgt;
      if (trap) begin
        m_mcause = cause; m_mtval = tval; m_mepc = pc;
        m_mpp = m_mode; m_mode = 2'b11;
      end else if (live && mret) begin
        m_mode = m_mpp; m_mpp = 2'b00;
      end else if (live && sret) begin
        m_mode = 2'b01;
      end
      m_shadow = redir ? FD : ((m_shadow > 0) ? m_shadow - 1 : 0);
    end
  end

  // Compare every cycle once the model is anchored by a reset
  always @(negedge clk) begin
    bit live, trap, is_irq, redir, sq;
    logic [31:0] cause, tval, tgt;
    if (m_ok) begin
      model_eval(live, trap, is_irq, cause, tval, tgt, redir, sq);
      chk("m_squash",  {31'b0, squash},  {31'b0, sq});
      chk("m_flush",   {31'b0, flush_v}, {31'b0, m_flush});
      chk("m_exc",     {31'b0, exc},     {31'b0, m_exc});
      chk("m_pc_data", pc_data, m_pc_data);
      chk("m_mcause",  mcause,  m_mcause);
      chk("m_mtval",   mtval,   m_mtval);
      chk("m_mepc",    mepc_q,  m_mepc);
      chk("m_mode",    {30'b0, mode}, {30'b0, m_mode});
      chk("m_mpp",     {30'b0, mpp},  {30'b0, m_mpp});
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0]  f;      // pc_mis,ill,brk,ldm,ldf,stm,stf,ecall
    logic        ie;
    logic [2:0]  irqv;
    logic [31:0] cause;
    logic [31:0] tval;
  } vec_t;

  vec_t tbl[8];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inst_v = 0; pc_mis = 0; ill = 0; brk = 0; ldm = 0; ldf = 0; stm = 0; stf = 0;
    ecall = 0; mret = 0; sret = 0; br_v = 0; irq = '0; mie = 0;
  endtask

  task automatic idle2();
    clr(); cyc(); cyc();
  endtask

  initial begin
    reset_n = 0; clr();
    pc = 0; br_pc = 0; mem_adr = 0; mtvec = 32'h8000; mepc = 32'h500; sepc = 32'h700;
    tbl[0] = '{8'b0111_0000, 1'b0, 3'b000, 32'd2,  32'h0};
    tbl[1] = '{8'b0010_0100, 1'b0, 3'b000, 32'd3,  32'h0};
    tbl[2] = '{8'b0000_1010, 1'b0, 3'b000, 32'd5,  32'h2004};
    tbl[3] = '{8'b0000_0101, 1'b0, 3'b000, 32'd6,  32'h2004};
    tbl[4] = '{8'b0000_0010, 1'b0, 3'b000, 32'd7,  32'h2004};
    tbl[5] = '{8'b1100_0000, 1'b0, 3'b000, 32'd0,  32'h3000};
    tbl[6] = '{8'b0001_0000, 1'b0, 3'b001, 32'd4,  32'h2004};
    tbl[7] = '{8'b0000_0000, 1'b1, 3'b001, 32'h8000_0003, 32'h0};
    cyc(); cyc();
    reset_n = 1;
    chk("rst_mode", {30'b0, mode}, 32'h3);
    chk("rst_mpp", {30'b0, mpp}, 32'h0);
    chk("rst_flush", {31'b0, flush_v}, 32'h0);
    chk("rst_exc", {31'b0, exc}, 32'h0);

    // plain add
    inst_v = 1; pc = 32'h100; #1;
    chk("add_squash", {31'b0, squash}, 32'h0);
    cyc();
    chk("add_flush", {31'b0, flush_v}, 32'h0);

    // branch and its flush shadow
    clr(); inst_v = 1; pc = 32'h200; br_v = 1; br_pc = 32'h300; #1;
    chk("br_squash", {31'b0, squash}, 32'h0);
    cyc();
    chk("br_flush", {31'b0, flush_v}, 32'h1);
    chk("br_pc_data", pc_data, 32'h300);
    clr(); inst_v = 1; pc = 32'h204; #1;
    chk("shadow1_squash", {31'b0, squash}, 32'h1);
    cyc();
    chk("shadow1_flush", {31'b0, flush_v}, 32'h0);
    clr(); inst_v = 1; pc = 32'h208; ill = 1; #1;
    chk("shadow2_squash", {31'b0, squash}, 32'h1);
    cyc();
    chk("shadow2_no_exc", {31'b0, exc}, 32'h0);
    clr(); inst_v = 1; pc = 32'h20C; #1;
    chk("post_shadow_squash", {31'b0, squash}, 32'h0);
    cyc();

    // mret from M with mpp=U, then ecall in U
    clr(); inst_v = 1; pc = 32'h240; mret = 1; #1;
    chk("mret_squash", {31'b0, squash}, 32'h1);
    cyc();
    chk("mret_pc_data", pc_data, 32'h500);
    chk("mret_mode", {30'b0, mode}, 32'h0);
    idle2();
    inst_v = 1; pc = 32'h504; ecall = 1; cyc();
    chk("ecall_u_cause", mcause, 32'd8);
    chk("ecall_u_mode", {30'b0, mode}, 32'h3);
    chk("ecall_u_mpp", {30'b0, mpp}, 32'h0);
    chk("ecall_u_pc_data", pc_data, 32'h8000);
    idle2();

    // misaligned load
    inst_v = 1; pc = 32'h400; ldm = 1; mem_adr = 32'h1002; cyc();
    chk("ldm_exc", {31'b0, exc}, 32'h1);
    chk("ldm_cause", mcause, 32'd4);
    chk("ldm_mtval", mtval, 32'h1002);
    chk("ldm_mepc", mepc_q, 32'h400);
    chk("ldm_pc_data", pc_data, 32'h8000);
    chk("ldm_mpp", {30'b0, mpp}, 32'h3);
    clr(); cyc();
    chk("ldm_exc_pulse", {31'b0, exc}, 32'h0);
    cyc();

    // vectored interrupt beats a simultaneous branch
    mtvec = 32'h8001;
    inst_v = 1; pc = 32'h600; mie = 1; irq = 3'b110; br_v = 1; br_pc = 32'h9990; cyc();
    chk("irq_cause", mcause, 32'h8000_000B);
    chk("irq_pc_data", pc_data, 32'h802C);
    chk("irq_mtval", mtval, 32'h0);
    chk("irq_mepc", mepc_q, 32'h600);
    idle2();

    // sret then ecall in S (synchronous trap not vectored)
    inst_v = 1; pc = 32'h640; sret = 1; cyc();
    chk("sret_pc_data", pc_data, 32'h700);
    chk("sret_mode", {30'b0, mode}, 32'h1);
    idle2();
    inst_v = 1; pc = 32'h704; ecall = 1; cyc();
    chk("ecall_s_cause", mcause, 32'd9);
    chk("ecall_s_pc_data", pc_data, 32'h8000);
    chk("ecall_s_mpp", {30'b0, mpp}, 32'h1);
    idle2();
    inst_v = 1; pc = 32'h708; mret = 1; cyc();
    chk("mret_s_mode", {30'b0, mode}, 32'h1);
    idle2();

    // priority table
    mem_adr = 32'h2004; br_pc = 32'h3000;
    for (int v = 0; v < 8; v++) begin
      inst_v = 1; pc = 32'h1000 + 32'(4 * v);
      {pc_mis, ill, brk, ldm, ldf, stm, stf, ecall} = tbl[v].f;
      mie = tbl[v].ie; irq = tbl[v].irqv;
      cyc();
      chk("tbl_exc", {31'b0, exc}, 32'h1);
      chk("tbl_cause", mcause, tbl[v].cause);
      chk("tbl_mtval", mtval, tbl[v].tval);
      idle2();
    end

    // reset in the middle of a flush shadow
    inst_v = 1; pc = 32'h800; br_v = 1; br_pc = 32'h900; cyc();
    clr(); reset_n = 0; cyc();
    reset_n = 1;
    chk("rst2_flush", {31'b0, flush_v}, 32'h0);
    chk("rst2_mode", {30'b0, mode}, 32'h3);
    inst_v = 1; pc = 32'h100; #1;
    chk("rst2_squash", {31'b0, squash}, 32'h0);
    cyc();
    clr(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exe_trap_unit.md
Name: exe_trap_unit

Overview:
- Parametrised trap and redirect controller for the EXE stage. It generalises the EXE-stage exception logic with a configurable flush shadow, asynchronous interrupt intake, vectored mtvec, mode-aware ecall causes and MPP tracking for mret.
- It receives qualified fault and control-flow flags for the instruction currently in EXE.
- It decides squash, trap or redirect for that instruction.
- It registers the trap CSR payload and the fetch redirect for WBK/CSR and IFU.

Parameters:
XLEN, 32, datapath and CSR width
FLUSH_DEPTH, 2, cycles after a redirect during which EXE instructions are squashed (>=1)
NB_IRQ, 3, machine interrupt lines; index i maps to cause code 4*i+3
VECTORED_EN, 1, 1 = honour mtvec MODE=01 for interrupts

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
inst_v_i  in  1  valid instruction in EXE
pc_i  in  XLEN  PC of EXE instruction
pc_misaligned_i  in  1  branch target misaligned
illegal_inst_i  in  1  illegal instruction
break_point_i  in  1  ebreak
ld_misaligned_i  in  1  load address misaligned
ld_fault_i  in  1  load access fault
st_misaligned_i  in  1  store address misaligned
st_fault_i  in  1  store access fault
ecall_i  in  1  ecall
mret_i  in  1  mret
sret_i  in  1  sret
branch_v_i  in  1  taken branch/jump
branch_pc_i  in  XLEN  branch target
mem_adr_i  in  XLEN  LSU effective address
irq_pending_i  in  NB_IRQ  pending and enabled interrupt lines
mie_i  in  1  mstatus.MIE
mtvec_i  in  XLEN  mtvec CSR
mepc_i  in  XLEN  mepc CSR
sepc_i  in  XLEN  sepc CSR
squash_o  out  1  combinational: EXE instruction killed (no RF/CSR/mem side effects)
flush_v_q_o  out  1  registered redirect pulse
pc_data_q_o  out  XLEN  redirect target
exception_q_o  out  1  registered trap pulse
mcause_q_o  out  XLEN  trap cause
mtval_q_o  out  XLEN  trap value
mepc_q_o  out  XLEN  trapping PC
core_mode_q_o  out  2  current privilege (00 U, 01 S, 11 M)
mpp_q_o  out  2  previous privilege for mret

Behaviour:
- Reset: shadow_cnt_q=0. core_mode_q_o=11. mpp_q_o=00. All other outputs 0. Reset applied mid-flush clears the shadow immediately.
- Shadow counter has width $clog2(FLUSH_DEPTH+1).
  - On redirect it loads FLUSH_DEPTH.
  - Otherwise it decrements while nonzero, independent of inst_v_i.
- kill = shadow_cnt_q!=0. ev = inst_v_i & ~kill. squash_o = kill | trap | (inst_v_i & redirect & ~branch_v_i).
  - A branch itself retires its link write.
  - A trapping or xret instruction does not write.
- Interrupt: irq_take = ev & mie_i & |irq_pending_i.
  - The highest set index wins.
  - code = 4*idx+3. mcause = {1'b1, code}.
- Sync exception priority (highest first), used when no irq_take:
  - pc_misaligned 0
  - illegal 2
  - break_point 3
  - ld_misaligned 4
  - ld_fault 5
  - st_misaligned 6
  - st_fault 7
  - ecall: 8 in U, 9 in S, 11 in M
- trap = irq_take | (ev & any fault/ecall).
- redirect = trap | ev & (mret_i | sret_i | branch_v_i).
- Target priority:
  - trap > mret > sret > branch.
  - Trap target is {mtvec_i[XLEN-1:2],2'b00}.
  - If VECTORED_EN, irq_take and mtvec_i[1:0]==01, the trap target is that base + 4*code.
  - mret target is mepc_i. sret target is sepc_i. Branch target is branch_pc_i.
- mtval:
  - pc_misaligned gives branch_pc_i.
  - ld/st misaligned or fault gives mem_adr_i.
  - Everything else gives 0.
- Registered outputs update on the clock edge after the EXE cycle (latency 1).
  - flush_v_q_o and exception_q_o are single-cycle pulses.
  - pc_data_q_o updates only on redirect.
  - mcause/mtval/mepc update only on trap and hold otherwise. mepc_q_o <= pc_i.
- Mode transitions:
  - trap: mpp <= core_mode, mode <= 11.
  - mret: mode <= mpp, mpp <= 00.
  - sret: mode <= 01.
  - Trap wins over simultaneous mret/sret/branch.
- No redirect can occur while kill=1. Squashed faults never trap.

Decomposition:
- Shared package holds:
  - the cause-code constants (CAUSE_PC_MISAL..CAUSE_ECALL_M)
  - privilege mode localparams (PRIV_U/S/M)
  - the mtvec MODE encodings
- One sub-module, trap_prio_enc, is natural. It takes the fault vector, irq vector and mode, and produces trap, is_irq and cause.

Test Plan:
- Reset, then an add at pc 0x100 with no flags -> squash_o=0, flush_v_q_o=0, core_mode_q_o=11.
- Branch at pc 0x200 with target 0x300 (FLUSH_DEPTH=2) -> flush_v_q_o=1 and pc_data_q_o=0x300 next cycle. The next 2 EXE instructions get squash_o=1. An illegal inst on the second one does not trap.
- Load at pc 0x400 with mem_adr_i=0x1002 and ld_misaligned_i, mtvec=0x8000 -> mcause=4, mtval=0x1002, mepc=0x400, pc_data=0x8000, exception_q_o pulse.
- mret in M with mpp=00 and mepc_i=0x500 -> pc_data=0x500, mode 00. A following ecall -> mcause=8, mode 11, mpp_q_o=00.
- Interrupt test: mtvec=0x8001, mie=1, irq_pending=3'b110, with branch_v_i also set -> interrupt wins. Result: mcause=0x8000000B, pc_data=0x802C, branch ignored.
- Assert reset_n=0 while shadow_cnt_q=2 -> the next instruction after reset is not squashed.
